key_debounce_pulse: RTL and testbench



---
 rtl/counter_pkg.sv | 21 ++
 rtl/sync_2ff.sv | 30 +++
 rtl/key_debounce_pulse.sv | 112 +++++++++++
 tb/tb_key_debounce_pulse.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// +--------------------------------------------------------------+
// | counter_pkg: shared debounce FSM states and default timing    |
// | Rev 1.0                                                      |
// +--------------------------------------------------------------+
`default_nettype none

package counter_pkg;

  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    PRESS_CHK   = 2'd1,
    PRESSED     = 2'd2,
    RELEASE_CHK = 2'd3
  } state_t;

  // 20 ms at 50 MHz
  localparam int DEBOUNCE_DEFAULT = 1000000;

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// +--------------------------------------------------------------+
// | sync_2ff: 1-bit two-flop synchronizer, sync active-low reset  |
// | Rev 1.0                                                      |
// +--------------------------------------------------------------+
`default_nettype none

module sync_2ff #(
  parameter logic RESET_VALUE = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic r_s1;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_s1 <= RESET_VALUE;
      q    <= RESET_VALUE;
    end else begin
      r_s1 <= d;
      q    <= r_s1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/key_debounce_pulse.sv
// +--------------------------------------------------------------+
// | key_debounce_pulse: active-low button debounce with press /   |
// | release strobes and a glitch-free count clock. Rev 1.0       |
// +--------------------------------------------------------------+
`default_nettype none

module key_debounce_pulse
  import counter_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic key_n,
  output logic key_level,
  output logic key_pulse,
  output logic release_pulse,
  output logic count_clock
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             w_s_key;
  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_press;
  logic             w_release;
  logic             w_level_next;

  sync_2ff #(
    .RESET_VALUE (1'b1)
  ) u_sync (
    .clock (clock),
    .reset (reset),
    .d     (key_n),
    .q     (w_s_key)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state       <= RELEASED;
      r_cnt         <= '0;
      key_level     <= 1'b0;
      key_pulse     <= 1'b0;
      release_pulse <= 1'b0;
      count_clock   <= 1'b1;
    end else begin
      r_state       <= w_state_next;
      r_cnt         <= w_cnt_next;
      key_level     <= w_level_next;
      key_pulse     <= w_press;
      release_pulse <= w_release;
      count_clock   <= ~w_level_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_press      = 1'b0;
    w_release    = 1'b0;
    case (r_state)
      RELEASED: begin
        if (!w_s_key) begin
          w_state_next = PRESS_CHK;
          w_cnt_next   = '0;
        end
      end
      PRESS_CHK: begin
        if (w_s_key) begin
          w_state_next = RELEASED;
          w_cnt_next   = '0;
        end else if (r_cnt == c_cnt_max) begin
          w_state_next = PRESSED;
          w_press      = 1'b1;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      PRESSED: begin
        if (w_s_key) begin
          w_state_next = RELEASE_CHK;
          w_cnt_next   = '0;
        end
      end
      RELEASE_CHK: begin
        if (!w_s_key) begin
          w_state_next = PRESSED;
          w_cnt_next   = '0;
        end else if (r_cnt == c_cnt_max) begin
          w_state_next = RELEASED;
          w_release    = 1'b1;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_next = RELEASED;
        w_cnt_next   = '0;
      end
    endcase
  end

  // Level follows the next state so it lines up with the strobes
  assign w_level_next = (w_state_next == PRESSED) || (w_state_next == RELEASE_CHK);

endmodule

`default_nettype wire

// File: tb/tb_key_debounce_pulse.sv
// Self-checking bench for key_debounce_pulse with N=8 and a run-length
// reference model plus a downstream 4-bit counter / seven-segment decode.
`default_nettype none

module tb_key_debounce_pulse;

  localparam int N = 8;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic key_n = 1'b0;
  logic key_level, key_pulse, release_pulse, count_clock;

  int checks = 0;
  int fails  = 0;

  // Reference model state
  logic [1:0] m_pipe  = 2'b11;
  logic       m_level = 1'b0;
  logic       m_press = 1'b0;
  logic       m_rel   = 1'b0;
  int         m_run   = 0;
  int         m_npress = 0;

  // Downstream 4-bit counter clocked by the falling edge of count_clock
  logic [3:0] ds_cnt = 4'd0;
  logic       ds_clr = 1'b0;

  key_debounce_pulse #(.DEBOUNCE_CYCLES(N)) dut (
    .clock         (clock),
    .reset         (reset),
    .key_n         (key_n),
    .key_level     (key_level),
    .key_pulse     (key_pulse),
    .release_pulse (release_pulse),
    .count_clock   (count_clock)
  );

  always #5 clock = ~clock;

  always @(negedge count_clock or posedge ds_clr) begin
    if (ds_clr) ds_cnt <= 4'd0;
    else        ds_cnt <= ds_cnt + 4'd1;
  end

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'h0: seg7 = 7'b1000000; 4'h1: seg7 = 7'b1111001;
      4'h2: seg7 = 7'b0100100; 4'h3: seg7 = 7'b0110000;
      4'h4: seg7 = 7'b0011001; 4'h5: seg7 = 7'b0010010;
      4'h6: seg7 = 7'b0000010; 4'h7: seg7 = 7'b1111000;
      4'h8: seg7 = 7'b0000000; 4'h9: seg7 = 7'b0010000;
      4'hA: seg7 = 7'b0001000; 4'hB: seg7 = 7'b0000011;
      4'hC: seg7 = 7'b1000110; 4'hD: seg7 = 7'b0100001;
      4'hE: seg7 = 7'b0000110; default: seg7 = 7'b0001110;
    endcase
  endfunction

  // One rising edge; the model accepts a level change once the synchronized
  // input has disagreed with it for N+1 consecutive edges.
  task automatic tick();
    logic seen;
    @(posedge clock);
    m_press = 1'b0;
    m_rel   = 1'b0;
    if (!reset) begin
      m_pipe  = 2'b11;
      m_level = 1'b0;
      m_run   = 0;
    end else begin
      seen   = m_pipe[1];
      m_pipe = {m_pipe[0], key_n};
      if (seen == m_level) begin
        m_run++;
        if (m_run == N + 1) begin
          m_level = ~m_level;
          m_run   = 0;
          if (m_level) begin m_press = 1'b1; m_npress++; end
          else         m_rel = 1'b1;
        end
      end else begin
        m_run = 0;
      end
    end
    #1;
  endtask

  task automatic settle_released();
    key_n = 1'b1;
    repeat (2 * N + 4) tick();
  endtask

  task automatic test_reset();
    int np;
    reset = 1'b0;
    key_n = 1'b0;
    repeat (3) tick();
    checks++;
    if ({key_level, key_pulse, release_pulse, count_clock} !== 4'b0001) begin
      fails++;
      $display("FAIL reset_values: got %b expected 0001", {key_level, key_pulse, release_pulse, count_clock});
    end
    reset = 1'b1;
    np = 0;
    for (int e = 0; e <= 12; e++) begin
      tick();
      if (key_pulse) np++;
      checks++;
      if (key_pulse !== (e == 10)) begin
        fails++;
        $display("FAIL reset_no_early_pulse: edge %0d key_pulse=%b expected %b", e, key_pulse, (e == 10));
      end
    end
    checks++;
    if (np != 1) begin
      fails++;
      $display("FAIL reset_pulse_count: got %0d expected 1", np);
    end
    settle_released();
  endtask

  task automatic test_press();
    int np;
    np = 0;
    key_n = 1'b0;
    for (int e = 0; e < 110; e++) begin
      tick();
      if (key_pulse) np++;
      checks++;
      if (key_pulse !== (e == 10) || key_level !== (e >= 10) || count_clock !== (e < 10)) begin
        fails++;
        $display("FAIL press_timing: edge %0d got pulse/level/cc=%b%b%b expected %b%b%b",
                 e, key_pulse, key_level, count_clock, (e == 10), (e >= 10), (e < 10));
      end
    end
    checks++;
    if (np != 1) begin
      fails++;
      $display("FAIL press_no_repeat: got %0d pulses expected 1", np);
    end
  endtask

  task automatic test_release();
    key_n = 1'b1;
    for (int e = 0; e < 14; e++) begin
      tick();
      checks++;
      if (release_pulse !== (e == 10) || key_pulse !== 1'b0 || count_clock !== (e >= 10)) begin
        fails++;
        $display("FAIL release_timing: edge %0d got rel/key/cc=%b%b%b expected %b0%b",
                 e, release_pulse, key_pulse, count_clock, (e == 10), (e >= 10));
      end
    end
  endtask

  task automatic test_glitch();
    int np;
    np = 0;
    key_n = 1'b0;
    repeat (5) begin tick(); if (key_pulse) np++; end
    key_n = 1'b1;
    tick();
    if (key_pulse) np++;
    checks++;
    if (np != 0) begin
      fails++;
      $display("FAIL glitch_no_pulse: got %0d pulses expected 0", np);
    end
    key_n = 1'b0;
    for (int e = 0; e < 20; e++) begin
      tick();
      checks++;
      if (key_pulse !== (e == 10)) begin
        fails++;
        $display("FAIL glitch_final_press: edge %0d key_pulse=%b expected %b", e, key_pulse, (e == 10));
      end
    end
    settle_released();
  endtask

  task automatic test_reset_mid();
    int np;
    key_n = 1'b0;
    repeat (8) tick();
    reset = 1'b0;
    tick();
    checks++;
    if ({key_level, key_pulse, release_pulse, count_clock} !== 4'b0001) begin
      fails++;
      $display("FAIL reset_mid_debounce: got %b expected 0001", {key_level, key_pulse, release_pulse, count_clock});
    end
    reset = 1'b1;
    np = 0;
    for (int e = 0; e < 16; e++) begin
      tick();
      if (key_pulse) np++;
    end
    checks++;
    if (np != 1) begin
      fails++;
      $display("FAIL reset_mid_repress: got %0d pulses expected 1", np);
    end
    settle_released();
  endtask

  task automatic test_random();
    int hold;
    hold = 0;
    for (int c = 0; c < 2000; c++) begin
      if (hold == 0) begin
        key_n = $urandom_range(0, 1);
        hold  = $urandom_range(1, 14);
      end
      hold--;
      tick();
      checks++;
      if ({key_level, key_pulse, release_pulse, count_clock} !== {m_level, m_press, m_rel, ~m_level}) begin
        fails++;
        $display("FAIL random_model: cycle %0d got %b expected %b", c,
                 {key_level, key_pulse, release_pulse, count_clock}, {m_level, m_press, m_rel, ~m_level});
      end
    end
    settle_released();
  endtask

  task automatic test_counter();
    ds_clr = 1'b1;
    #1;
    ds_clr = 1'b0;
    for (int p = 1; p <= 16; p++) begin
      key_n = 1'b0;
      repeat (N + 4) tick();
      key_n = 1'b1;
      repeat (N + 4) tick();
      checks++;
      if (ds_cnt !== 4'(p)) begin
        fails++;
        $display("FAIL counter_step: press %0d got %0d expected %0d", p, ds_cnt, 4'(p));
      end
    end
    checks++;
    if (seg7(ds_cnt) !== 7'b1000000) begin
      fails++;
      $display("FAIL counter_wrap_seg: got %b expected 1000000", seg7(ds_cnt));
    end
  endtask

  initial begin
    test_reset();
    test_press();
    test_release();
    test_glitch();
    test_reset_mid();
    test_random();
    test_counter();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
